// File: rtl/ysyx_22050518_regfile_mp.sv
// Multi-ported integer register file with a per-register busy scoreboard.
// x0 is hardwired to zero; optional same-cycle write-to-read forwarding.
module ysyx_22050518_regfile_mp #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*AW-1:0]    rd_addr_i,
    output logic [NRD*XLEN-1:0]  rd_data_o,
    output logic [NRD-1:0]       rd_busy_o,
    input  logic [NWR-1:0]       wr_en_i,
    input  logic [NWR*AW-1:0]    wr_addr_i,
    input  logic [NWR*XLEN-1:0]  wr_data_i,
    input  logic                 iss_en_i,
    input  logic [AW-1:0]        iss_addr_i,
    output logic [XLEN-1:0]      a0_o
);

    logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREG-1:0]           busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Later write ports overwrite earlier ones; issue is applied last so set beats clear.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] != '0)) begin
                regs_d[wr_addr_i[w*AW +: AW]] = wr_data_i[w*XLEN +: XLEN];
                busy_d[wr_addr_i[w*AW +: AW]] = 1'b0;
            end
        end
        if (iss_en_i && (iss_addr_i != '0)) begin
            busy_d[iss_addr_i] = 1'b1;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdat;
        logic            rbsy;

        assign ra = rd_addr_i[p*AW +: AW];

        // Forwarding is suppressed during reset since those writes are discarded.
        always_comb begin
            rdat = regs_q[ra];
            rbsy = busy_q[ra];
            if ((BYPASS != 0) && rst_n) begin
                for (int w = 0; w < NWR; w++) begin
                    if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == ra)) begin
                        rdat = wr_data_i[w*XLEN +: XLEN];
                        rbsy = 1'b0;
                    end
                end
            end
            if (ra == '0) begin
                rdat = '0;
                rbsy = 1'b0;
            end
        end

        assign rd_data_o[p*XLEN +: XLEN] = rdat;
        assign rd_busy_o[p]              = rbsy;
    end

    assign a0_o = regs_q[10];

endmodule

// File: tb/tb_ysyx_22050518_regfile_mp.sv
// Bench for the register file: forwarding and stored-only variants side by side,
// compared against an array-based reference of registers and busy bits.
module tb_ysyx_22050518_regfile_mp;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0][4:0]   rd_addr;
    logic [1:0]        wr_en;
    logic [1:0][4:0]   wr_addr;
    logic [1:0][63:0]  wr_data;
    logic              iss_en;
    logic [4:0]        iss_addr;

    logic [1:0][63:0]  rdata1, rdata0;
    logic [1:0]        rbusy1, rbusy0;
    logic [63:0]       a0_1, a0_0;

    int total = 0;
    int bad   = 0;

    logic [63:0] mregs [32];
    logic        mbusy [32];

    always #5 clk = ~clk;

    ysyx_22050518_regfile_mp #(.XLEN(64), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1)) u_dut_byp (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rdata1),
        .rd_busy_o  (rbusy1),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .iss_en_i   (iss_en),
        .iss_addr_i (iss_addr),
        .a0_o       (a0_1)
    );

    ysyx_22050518_regfile_mp #(.XLEN(64), .NREG(32), .NRD(2), .NWR(2), .BYPASS(0)) u_dut_nobyp (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rdata0),
        .rd_busy_o  (rbusy0),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .iss_en_i   (iss_en),
        .iss_addr_i (iss_addr),
        .a0_o       (a0_0)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_data(input int p, input bit byp);
        logic [4:0]  a;
        logic [63:0] d;
        a = rd_addr[p];
        if (a == 5'd0) return 64'd0;
        d = mregs[a];
        if (byp && rst_n === 1'b1)
            for (int w = 0; w < 2; w++)
                if (wr_en[w] && wr_addr[w] == a) d = wr_data[w];
        return d;
    endfunction

    function automatic logic exp_busy(input int p, input bit byp);
        logic [4:0] a;
        logic       b;
        a = rd_addr[p];
        if (a == 5'd0) return 1'b0;
        b = mbusy[a];
        if (byp && rst_n === 1'b1)
            for (int w = 0; w < 2; w++)
                if (wr_en[w] && wr_addr[w] == a) b = 1'b0;
        return b;
    endfunction

    task automatic check_all();
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("rd%0d_data_byp a=%0d", p, rd_addr[p]), rdata1[p], exp_data(p, 1'b1));
            chk($sformatf("rd%0d_busy_byp a=%0d", p, rd_addr[p]), {63'd0, rbusy1[p]}, {63'd0, exp_busy(p, 1'b1)});
            chk($sformatf("rd%0d_data_nobyp a=%0d", p, rd_addr[p]), rdata0[p], exp_data(p, 1'b0));
            chk($sformatf("rd%0d_busy_nobyp a=%0d", p, rd_addr[p]), {63'd0, rbusy0[p]}, {63'd0, exp_busy(p, 1'b0)});
        end
        chk("a0_byp", a0_1, mregs[10]);
        chk("a0_nobyp", a0_0, mregs[10]);
    endtask

    task automatic model_clock();
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                mregs[r] = 64'd0;
                mbusy[r] = 1'b0;
            end
        end else begin
            for (int w = 0; w < 2; w++)
                if (wr_en[w] && wr_addr[w] != 5'd0) begin
                    mregs[wr_addr[w]] = wr_data[w];
                    mbusy[wr_addr[w]] = 1'b0;
                end
            if (iss_en && iss_addr != 5'd0) mbusy[iss_addr] = 1'b1;
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 2ns later, well before the rising edge.
    task automatic step();
        #2;
        check_all();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic idle();
        rst_n  = 1'b1;
        wr_en  = 2'b00;
        iss_en = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        for (int r = 0; r < 32; r++) begin
            mregs[r] = 64'd0;
            mbusy[r] = 1'b0;
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        idle();

        // all addresses read zero and not busy after reset
        for (int a = 0; a < 32; a += 2) begin
            rd_addr[0] = 5'(a);
            rd_addr[1] = 5'(a + 1);
            #1;
            chk("reset_rd0", rdata1[0], 64'd0);
            chk("reset_rd1", rdata1[1], 64'd0);
            chk("reset_busy", {62'd0, rbusy1}, 64'd0);
            step();
        end
        chk("reset_a0", a0_1, 64'd0);

        // x5 write, then read back
        wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 64'h1234_5678_9ABC_DEF0;
        step();
        idle();
        rd_addr[0] = 5'd5; rd_addr[1] = 5'd0;
        #1 chk("x5_read", rdata1[0], 64'h1234_5678_9ABC_DEF0);
        step();
        wr_en = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 64'hFFFF;
        step();
        idle();
        #1 chk("x0_read", rdata1[1], 64'd0);
        step();

        // dual write to x7: port 1 wins; forwarded vs stored
        wr_en = 2'b01; wr_addr[0] = 5'd7; wr_data[0] = 64'h33;
        step();
        wr_en = 2'b11; wr_addr[0] = 5'd7; wr_data[0] = 64'hAA; wr_addr[1] = 5'd7; wr_data[1] = 64'hBB;
        rd_addr[0] = 5'd7;
        #1;
        chk("x7_fwd", rdata1[0], 64'hBB);
        chk("x7_nofwd", rdata0[0], 64'h33);
        step();
        idle();
        #1;
        chk("x7_stored_byp", rdata1[0], 64'hBB);
        chk("x7_stored_nobyp", rdata0[0], 64'hBB);
        step();

        // scoreboard on x10
        iss_en = 1'b1; iss_addr = 5'd10;
        step();
        idle();
        rd_addr[0] = 5'd10;
        #1 chk("x10_busy", {63'd0, rbusy1[0]}, 64'd1);
        wr_en = 2'b10; wr_addr[1] = 5'd10; wr_data[1] = 64'h2A;
        #1;
        chk("x10_busy_fwd", {63'd0, rbusy1[0]}, 64'd0);
        chk("x10_busy_nofwd", {63'd0, rbusy0[0]}, 64'd1);
        chk("x10_data_fwd", rdata1[0], 64'h2A);
        step();
        idle();
        #1;
        chk("a0_after", a0_1, 64'h2A);
        chk("x10_busy_after", {63'd0, rbusy0[0]}, 64'd0);
        step();

        // issue and write same register, same cycle
        iss_en = 1'b1; iss_addr = 5'd3;
        wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 64'h11;
        step();
        idle();
        rd_addr[1] = 5'd3;
        #1;
        chk("x3_busy", {63'd0, rbusy1[1]}, 64'd1);
        chk("x3_data", rdata1[1], 64'h11);
        step();

        // reset mid-operation
        iss_en = 1'b1; iss_addr = 5'd4;
        wr_en = 2'b01; wr_addr[0] = 5'd4; wr_data[0] = 64'h55;
        step();
        idle();
        rst_n = 1'b0;
        wr_en = 2'b10; wr_addr[1] = 5'd4; wr_data[1] = 64'h99;
        step();
        idle();
        rd_addr[0] = 5'd4;
        #1;
        chk("x4_after_rst", rdata1[0], 64'd0);
        chk("x4_busy_after_rst", {63'd0, rbusy1[0]}, 64'd0);
        chk("a0_after_rst", a0_1, 64'd0);
        step();

        // random traffic concentrated on a few registers to force collisions
        for (int c = 0; c < 400; c++) begin
            rst_n      = ($urandom_range(0, 39) != 0);
            rd_addr[0] = 5'($urandom_range(0, 11));
            rd_addr[1] = 5'($urandom_range(0, 11));
            wr_en      = 2'($urandom_range(0, 3));
            wr_addr[0] = 5'($urandom_range(0, 11));
            wr_addr[1] = ($urandom_range(0, 3) == 0) ? wr_addr[0] : 5'($urandom_range(0, 11));
            wr_data[0] = {$urandom, $urandom};
            wr_data[1] = {$urandom, $urandom};
            iss_en     = ($urandom_range(0, 2) == 0);
            iss_addr   = 5'($urandom_range(0, 11));
            step();
        end
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22050518_regfile_mp.md
YSYX_22050518_REGFILE_MP -- requirements
Module: ysyx_22050518_regfile_mp

Interface
REQ-001 Parameter XLEN, 64, register width in bits.
REQ-002 Parameter NREG, 32, number of architectural registers; power of two, >= 16; AW = log2(NREG).
REQ-003 Parameter NRD, 2, number of read ports, 1..4.
REQ-004 Parameter NWR, 2, number of write ports, 1..2.
REQ-005 Parameter BYPASS, 1, 1 = same-cycle write-to-read forwarding on; 0 = off.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 rd_addr  in  NRD*AW  read addresses; port p at bits [p*AW +: AW].
REQ-009 rd_data  out  NRD*XLEN  read data; port p at bits [p*XLEN +: XLEN].
REQ-010 rd_busy  out  NRD  per read port: addressed register awaits a pending write.
REQ-011 wr_en  in  NWR  per write port enable.
REQ-012 wr_addr  in  NWR*AW  write addresses, packed as rd_addr.
REQ-013 wr_data  in  NWR*XLEN  write data, packed as rd_data.
REQ-014 iss_en  in  1  issue strobe: mark iss_addr as pending write.
REQ-015 iss_addr  in  AW  destination register of the issued instruction.
REQ-016 a0  out  XLEN  debug view of register 10, registered value, never bypassed.

Function
REQ-017 Register 0 SHALL read as 0 on every port; writes and issues to address 0 are ignored; register 0 never busy.
REQ-018 Reads SHALL be combinational from addresses, zero added latency.
REQ-019 Write: at rising edge, wr_en[w] with wr_addr[w] != 0 SHALL load wr_data[w]; visible to non-bypassed reads the following cycle.
REQ-020 Two write ports to the same nonzero address in one cycle: higher-indexed port SHALL win.
REQ-021 BYPASS=1: read of nonzero address matching an enabled write in the same cycle SHALL return that write data (highest-indexed matching port); BYPASS=0: stored value.
REQ-022 Scoreboard: one busy bit per register, all 0 after reset.
REQ-023 Busy set at rising edge when iss_en and iss_addr != 0.
REQ-024 Busy cleared at rising edge when any enabled write port targets that address.
REQ-025 Same-cycle issue and write to the same address: set SHALL win (bit remains 1).
REQ-026 Issue to an already busy register: bit remains 1, no error, no counting.
REQ-027 rd_busy[p] = busy[rd_addr[p]]; with BYPASS=1 SHALL read 0 when a same-cycle enabled write targets that address (data forwarded); address 0 always 0.
REQ-028 Write to a non-busy register SHALL update data normally; busy unchanged.

Reset
REQ-029 rst_n low at rising edge SHALL clear all registers to 0 and all busy bits to 0.
REQ-030 Writes and issues in a reset cycle SHALL be ignored; reset dominates mid-operation.
REQ-031 After reset: rd_data all 0, rd_busy all 0, a0 = 0 (combinational outputs with bypass off the write path, i.e. no forwarding while rst_n low).

Verification
REQ-032 Reset, then read all addresses on all ports -> rd_data 0, rd_busy 0, a0 0.
REQ-033 Write port0 x5=0x1234_5678_9ABC_DEF0; next cycle read x5 -> 0x123456789ABCDEF0; write x0=0xFFFF -> x0 reads 0.
REQ-034 BYPASS=1: same cycle wr port0 x7=0xAA, port1 x7=0xBB, read x7 -> 0xBB combinationally; next cycle stored 0xBB; BYPASS=0 same cycle -> old value.
REQ-035 Issue x10 -> next cycle rd_busy 1 on x10 read; write x10=0x2A -> same cycle rd_busy 0 (BYPASS=1), rd_data 0x2A; next cycle a0=0x2A, busy 0.
REQ-036 Same cycle issue x3 and write x3=0x11 -> next cycle x3 busy 1, data 0x11.
REQ-037 Write x4=0x55 and issue x4, then rst_n low one cycle -> x4 reads 0, busy 0.
